mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_slot.sv | 44 ++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master BRAM port arbiter.
package mem_arbiter_pkg;

  // Width of the slave window addresses (full 32-bit byte address space).
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  // Unsigned window test: base inclusive, top exclusive.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-entry request buffer: loads when empty, a load while pending is dropped.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load_i,
  input  logic     clr_i,
  input  mem_req_t req_i,
  output logic     pend_o,
  output mem_req_t req_o
);

  logic     pend_q, pend_d;
  mem_req_t req_q, req_d;

  // Next entry contents: clear on grant, capture only into an empty slot.
  always_comb begin
    pend_d = pend_q;
    req_d  = req_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end
    if (load_i && !pend_q) begin
      pend_d = 1'b1;
      req_d  = req_i;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  assign pend_o = pend_q;
  assign req_o  = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one BRAM port between fetch (m0) and load/store (m1).
// Optional BUSY watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] base_addr      = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] top_addr       = 32'h9000_0000,
  parameter int unsigned       timeout_cycles = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_ready,
  output logic              m0_error,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_ready,
  output logic              m1_error,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [31:0]       s_rdata,
  input  logic              s_ready
);

  if (timeout_cycles == 0) begin : g_bad_timeout
    $error("mem_arbiter: timeout_cycles must be nonzero");
  end

  mem_req_t   m0_req, m1_req, slot0_req, slot1_req, gnt_req;
  logic       pend0, pend1, clr0, clr1, grant;
  arb_state_t state_q, state_d;
  logic       last_q, last_d;       // master granted most recently (0/1)
  logic       owner_q, owner_d;     // master owning the current transaction
  logic       oor_q, oor_d;         // current grant is outside the window
  logic       err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic       s_valid_q, s_valid_d;
  mem_req_t   sreq_q, sreq_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  assign m0_req = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  mem_arbiter_slot u_slot0 (
    .clock (clock),
    .reset (reset),
    .load_i(m0_valid),
    .clr_i (clr0),
    .req_i (m0_req),
    .pend_o(pend0),
    .req_o (slot0_req)
  );

  mem_arbiter_slot u_slot1 (
    .clock (clock),
    .reset (reset),
    .load_i(m1_valid),
    .clr_i (clr1),
    .req_i (m1_req),
    .pend_o(pend1),
    .req_o (slot1_req)
  );

  // State and transaction registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      s_valid_q <= 1'b0;
      sreq_q    <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      oor_q     <= oor_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      s_valid_q <= s_valid_d;
      sreq_q    <= sreq_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state: round-robin grant in IDLE, completion wait in BUSY.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    oor_d     = oor_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    s_valid_d = 1'b0;
    sreq_d    = sreq_q;
    clr0      = 1'b0;
    clr1      = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    grant   = (pend0 && pend1) ? ~last_q : ~pend0;
    gnt_req = grant ? slot1_req : slot0_req;
    case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          last_d  = grant;
          owner_d = grant;
          clr0    = ~grant;
          clr1    = grant;
          state_d = BUSY;
`ifdef MEM_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
          // Out-of-range grants spend one BUSY cycle without s_valid, so the
          // error response lands two cycles after capture.
          if (in_window(gnt_req.addr, base_addr, top_addr)) begin
            s_valid_d = 1'b1;
            sreq_d    = gnt_req;
            oor_d     = 1'b0;
          end else begin
            oor_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (oor_q) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (s_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = s_rdata;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (cnt_q == 32'(timeout_cycles - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: response only to the owner while in RESP, slave fields registered.
  always_comb begin
    m0_ready = (state_q == RESP) && !owner_q;
    m1_ready = (state_q == RESP) && owner_q;
    m0_rdata = m0_ready ? rdata_q : '0;
    m1_rdata = m1_ready ? rdata_q : '0;
    m0_error = m0_ready && err_q;
    m1_error = m1_ready && err_q;
    s_valid  = s_valid_q;
    s_instr  = sreq_q.instr;
    s_addr   = sreq_q.addr;
    s_wdata  = sreq_q.wdata;
    s_wstrb  = sreq_q.wstrb;
  end

endmodule
